// File: rtl/fec_pkg.sv
// Shared definitions for the 2D-parity FEC path (encoder and decoder).
package fec_pkg;

  // Default frame geometry: WIDTH columns by DEPTH rows.
  localparam int FEC_WIDTH = 4;
  localparam int FEC_DEPTH = 4;
  localparam int FEC_CNT_W = 8;

  // One frame as it crosses from encoder to decoder.
  typedef struct packed {
    logic [FEC_DEPTH-1:0][FEC_WIDTH-1:0] data;
    logic [FEC_DEPTH-1:0]                row_parity;
    logic [FEC_WIDTH-1:0]                col_parity;
  } fec_frame_t;

endpackage : fec_pkg

// File: rtl/fec_parity_acc.sv
// Row accumulator for the FEC encoder: stores DEPTH rows, keeps per-row
// parity and a running column parity, and flags when the frame is complete.
module fec_parity_acc
  import fec_pkg::*;
#(
  parameter int WIDTH = FEC_WIDTH,
  parameter int DEPTH = FEC_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_accept,
  input  logic [WIDTH-1:0]            i_row,
  input  logic                        i_clear,
  output logic [DEPTH-1:0][WIDTH-1:0] o_rows,
  output logic [DEPTH-1:0]            o_row_par,
  output logic [WIDTH-1:0]            o_col_par,
  output logic                        o_full
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]            r_cnt;
  logic                        r_full;
  logic [DEPTH-1:0][WIDTH-1:0] r_rows;
  logic [DEPTH-1:0]            r_row_par;
  logic [WIDTH-1:0]            r_col_par;

  logic                        w_last;
  logic [WIDTH-1:0]            w_col_next;

  assign w_last = (r_cnt == LAST_IDX);

  // A handed-off frame restarts column parity from zero; an accepted row
  // folds in on top of that, so both can share one edge safely.
  assign w_col_next = (i_clear ? '0 : r_col_par) ^ (i_accept ? i_row : '0);

  // Row counter and frame-complete flag; completing a frame wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
      end
      if (i_accept && w_last) begin
        r_full <= 1'b1;
      end else if (i_clear) begin
        r_full <= 1'b0;
      end
    end
  end

  // Row storage and per-row parity captured as each row is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows    <= '0;
      r_row_par <= '0;
    end else if (i_accept) begin
      r_rows[r_cnt]    <= i_row;
      r_row_par[r_cnt] <= ^i_row;
    end
  end

  // Running column parity over the rows of the frame being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_par <= '0;
    end else begin
      r_col_par <= w_col_next;
    end
  end

  assign o_rows    = r_rows;
  assign o_row_par = r_row_par;
  assign o_col_par = r_col_par;
  assign o_full    = r_full;

endmodule : fec_parity_acc

// File: rtl/fec_frame_encoder.sv
// 2D-parity FEC frame encoder: packs DEPTH rows into a frame, computes even
// row/column parity, and hands the frame to the decoder through a held
// output register with a start strobe. The accumulator refills while the
// previous frame is held. A test-only injector flips one data bit on handoff.
module fec_frame_encoder
  import fec_pkg::*;
#(
  parameter int WIDTH = FEC_WIDTH,
  parameter int DEPTH = FEC_DEPTH,
  parameter int CNT_W = FEC_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            row_in,
  input  logic                        inj_en,
  input  logic [$clog2(DEPTH)-1:0]    inj_row,
  input  logic [$clog2(WIDTH)-1:0]    inj_col,
  output logic [DEPTH-1:0][WIDTH-1:0] data_out,
  output logic [DEPTH-1:0]            row_parity,
  output logic [WIDTH-1:0]            col_parity,
  output logic                        frame_valid,
  output logic                        frame_start,
  input  logic                        frame_ack,
  output logic [CNT_W-1:0]            frame_cnt
);

  logic                        w_acc_full;
  logic [DEPTH-1:0][WIDTH-1:0] w_acc_rows;
  logic [DEPTH-1:0]            w_acc_row_par;
  logic [WIDTH-1:0]            w_acc_col_par;
  logic                        w_accept;
  logic                        w_transfer;
  logic [DEPTH-1:0][WIDTH-1:0] w_inj_mask;

  logic [DEPTH-1:0][WIDTH-1:0] r_data_out;
  logic [DEPTH-1:0]            r_row_parity;
  logic [WIDTH-1:0]            r_col_parity;
  logic                        r_frame_valid;
  logic                        r_frame_start;
  logic [CNT_W-1:0]            r_frame_cnt;

  // Ready depends only on registered accumulator state, never on the ack.
  assign in_ready   = !w_acc_full;
  assign w_accept   = in_valid && !w_acc_full;
  assign w_transfer = w_acc_full && (!r_frame_valid || frame_ack);

  fec_parity_acc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_accept  (w_accept),
    .i_row     (row_in),
    .i_clear   (w_transfer),
    .o_rows    (w_acc_rows),
    .o_row_par (w_acc_row_par),
    .o_col_par (w_acc_col_par),
    .o_full    (w_acc_full)
  );

  // Single-bit flip mask for the injector; parity is deliberately left
  // computed from the clean data so the decoder sees a real error.
  always_comb begin
    w_inj_mask = '0;
    if (inj_en) begin
      w_inj_mask[inj_row][inj_col] = 1'b1;
    end
  end

  // Output frame register: load on handoff, otherwise hold data/parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_row_parity <= '0;
      r_col_parity <= '0;
    end else if (w_transfer) begin
      r_data_out   <= w_acc_rows ^ w_inj_mask;
      r_row_parity <= w_acc_row_par;
      r_col_parity <= w_acc_col_par;
    end
  end

  // Handshake state: valid/start strobe and the wrapping frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_transfer) begin
        r_frame_valid <= 1'b1;
        r_frame_start <= 1'b1;
        r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
      end else if (frame_ack && r_frame_valid) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign data_out    = r_data_out;
  assign row_parity  = r_row_parity;
  assign col_parity  = r_col_parity;
  assign frame_valid = r_frame_valid;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule : fec_frame_encoder

// File: tb/tb_fec_frame_encoder.sv
// Self-checking bench for fec_frame_encoder (WIDTH=4, DEPTH=4, CNT_W=8).
module tb_fec_frame_encoder;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       row_in;
  logic             inj_en;
  logic [1:0]       inj_row;
  logic [1:0]       inj_col;
  logic [3:0][3:0]  data_out;
  logic [3:0]       row_parity;
  logic [3:0]       col_parity;
  logic             frame_valid;
  logic             frame_start;
  logic             frame_ack;
  logic [7:0]       frame_cnt;

  always #5 clk = ~clk;

  fec_frame_encoder #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .row_in      (row_in),
    .inj_en      (inj_en),
    .inj_row     (inj_row),
    .inj_col     (inj_col),
    .data_out    (data_out),
    .row_parity  (row_parity),
    .col_parity  (col_parity),
    .frame_valid (frame_valid),
    .frame_start (frame_start),
    .frame_ack   (frame_ack),
    .frame_cnt   (frame_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rp;
    logic [3:0]  cp;
    logic [7:0]  cnt;
  } exp_t;

  // rows: row r in bits [4r+3:4r]
  typedef struct {
    logic [15:0] rows;
    logic        ie;
    logic [1:0]  ir;
    logic [1:0]  ic;
    logic [15:0] exp_data;
    logic [3:0]  exp_rp;
    logic [3:0]  exp_cp;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] rows, input logic ie,
                                 input logic [1:0] ir, input logic [1:0] ic,
                                 input logic [7:0] cnt);
    exp_t e;
    e.data = rows;
    e.rp   = 4'd0;
    e.cp   = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e.rp[r] = e.rp[r] ^ rows[4*r+c];
        e.cp[c] = e.cp[c] ^ rows[4*r+c];
      end
    end
    if (ie) e.data[4*ir+ic] = ~e.data[4*ir+ic];
    e.cnt = cnt;
    return e;
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 64) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready=0, expected 1 within 64 cycles");
    end
  endtask

  // Streams four rows; optionally waits until the handoff has freed the accumulator.
  task automatic send_frame(input logic [15:0] rows, input logic ie, input logic [1:0] ir,
                            input logic [1:0] ic, input bit wait_xfer);
    inj_en  = ie;
    inj_row = ir;
    inj_col = ic;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      row_in   = rows[4*r +: 4];
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (wait_xfer) wait_ready();
  endtask

  // Scoreboard monitor: each frame_start pops one expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && frame_start === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: frame_start=1 with no expected frame queued");
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_data", 32'(data_out), 32'(mon_e.data));
          check("sb_row_parity", 32'(row_parity), 32'(mon_e.rp));
          check("sb_col_parity", 32'(col_parity), 32'(mon_e.cp));
          check("sb_frame_cnt", 32'(frame_cnt), 32'(mon_e.cnt));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs[6];
  exp_t        ea;
  exp_t        eb;
  logic [15:0] rnd_rows;
  logic        rnd_ie;
  logic [1:0]  rnd_ir;
  logic [1:0]  rnd_ic;
  int          guard;

  initial begin
    vecs[0] = '{16'hF731, 1'b0, 2'd0, 2'd0, 16'hF731, 4'b0101, 4'b1010};
    vecs[1] = '{16'hFFFF, 1'b1, 2'd2, 2'd1, 16'hFDFF, 4'b0000, 4'b0000};
    vecs[2] = '{16'hAAAA, 1'b0, 2'd0, 2'd0, 16'hAAAA, 4'b0000, 4'b0000};
    vecs[3] = '{16'h1248, 1'b1, 2'd0, 2'd3, 16'h1240, 4'b1111, 4'b1111};
    vecs[4] = '{16'h0000, 1'b1, 2'd3, 2'd0, 16'h1000, 4'b0000, 4'b0000};
    vecs[5] = '{16'h6B0C, 1'b0, 2'd0, 2'd0, 16'h6B0C, 4'b0100, 4'b0001};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    row_in    = 4'd0;
    inj_en    = 1'b0;
    inj_row   = 2'd0;
    inj_col   = 2'd0;
    frame_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_row_parity", 32'(row_parity), 32'd0);
    check("rst_col_parity", 32'(col_parity), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First frame, 1111 x4, latency and strobe width
    frame_ack = 1'b1;
    model_cnt++;
    sb_q.push_back(model(16'hFFFF, 1'b0, 2'd0, 2'd0, model_cnt));
    in_valid = 1'b1;
    row_in   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t1_fv_low", 32'(frame_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("t1_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t1_fv_high", 32'(frame_valid), 32'd1);
    check("t1_fs_high", 32'(frame_start), 32'd1);
    check("t1_ready_back", 32'(in_ready), 32'd1);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_data", 32'(data_out), 32'hFFFF);
    @(posedge clk); #1;
    check("t1_fs_one_cycle", 32'(frame_start), 32'd0);
    check("t1_fv_acked", 32'(frame_valid), 32'd0);

    // Table-driven frames (parity patterns and injection)
    for (int v = 0; v < 6; v++) begin
      model_cnt++;
      sb_q.push_back('{vecs[v].exp_data, vecs[v].exp_rp, vecs[v].exp_cp, model_cnt});
      send_frame(vecs[v].rows, vecs[v].ie, vecs[v].ir, vecs[v].ic, 1'b1);
    end
    inj_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-fill discards the partial frame
    in_valid = 1'b1;
    row_in   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_data_out", 32'(data_out), 32'd0);
    check("mr_row_parity", 32'(row_parity), 32'd0);
    check("mr_col_parity", 32'(col_parity), 32'd0);
    check("mr_frame_valid", 32'(frame_valid), 32'd0);
    check("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    model_cnt = 8'd0;
    @(posedge clk); #1;
    model_cnt++;
    sb_q.push_back(model(16'hAAAA, 1'b0, 2'd0, 2'd0, model_cnt));
    send_frame(16'hAAAA, 1'b0, 2'd0, 2'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two frames with no ack
    frame_ack = 1'b0;
    check("bp_fv_idle", 32'(frame_valid), 32'd0);
    model_cnt++;
    ea = model(16'h5A3C, 1'b0, 2'd0, 2'd0, model_cnt);
    sb_q.push_back(ea);
    send_frame(16'h5A3C, 1'b0, 2'd0, 2'd0, 1'b1);
    model_cnt++;
    eb = model(16'h0F96, 1'b1, 2'd1, 2'd2, model_cnt);
    sb_q.push_back(eb);
    send_frame(16'h0F96, 1'b1, 2'd1, 2'd2, 1'b0);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_fv_held", 32'(frame_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_still_low", 32'(in_ready), 32'd0);
    check("bp_data_held", 32'(data_out), 32'(ea.data));
    check("bp_cnt_held", 32'(frame_cnt), 32'(ea.cnt));
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("bp_fv_stays", 32'(frame_valid), 32'd1);
    check("bp_fs_repulse", 32'(frame_start), 32'd1);
    check("bp_cnt_next", 32'(frame_cnt), 32'(eb.cnt));
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_fs_drop", 32'(frame_start), 32'd0);
    check("bp_fv_no_ack", 32'(frame_valid), 32'd1);

    // Ack releases the frame; data/parity hold
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check("rel_fv_low", 32'(frame_valid), 32'd0);
    check("rel_data_hold", 32'(data_out), 32'(eb.data));
    check("rel_rp_hold", 32'(row_parity), 32'(eb.rp));

    // Ack while nothing is held is ignored
    frame_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    frame_ack = 1'b0;
    check("idle_ack_fv", 32'(frame_valid), 32'd0);
    check("idle_ack_fs", 32'(frame_start), 32'd0);
    check("idle_ack_cnt", 32'(frame_cnt), 32'(eb.cnt));
    check("idle_ack_data", 32'(data_out), 32'(eb.data));
    check("idle_ack_ready", 32'(in_ready), 32'd1);

    // Random frames until the frame counter wraps
    frame_ack = 1'b1;
    guard     = 0;
    do begin
      rnd_rows = 16'($urandom);
      rnd_ie   = 1'($urandom_range(0, 1));
      rnd_ir   = 2'($urandom_range(0, 3));
      rnd_ic   = 2'($urandom_range(0, 3));
      model_cnt++;
      sb_q.push_back(model(rnd_rows, rnd_ie, rnd_ir, rnd_ic, model_cnt));
      send_frame(rnd_rows, rnd_ie, rnd_ir, rnd_ic, 1'b1);
      guard++;
    end while (model_cnt != 8'd0 && guard < 300);
    inj_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_wrap", 32'(frame_cnt), 32'd0);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fec_frame_encoder

// File: doc/fec_frame_encoder.md
# fec_frame_encoder

Upstream stage of the 2D-parity FEC path. Accepts payload one row per cycle over a valid/ready stream, packs DEPTH rows into a WIDTH×DEPTH frame, and computes even row and column parity. Presents the frame, its parity and a one-cycle start strobe to the decoder, with a test-only single-bit error injector. Double-buffered: the next frame fills while the current one is held.

## Interface
- WIDTH, 4, bits per row (columns)
- DEPTH, 4, rows per frame
- CNT_W, 8, width of frame counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  row_in valid
- in_ready  out  1  encoder can accept a row
- row_in  in  WIDTH  payload row
- inj_en  in  1  flip one data bit of the frame being transferred
- inj_row  in  $clog2(DEPTH)  row of bit to flip
- inj_col  in  $clog2(WIDTH)  column of bit to flip
- data_out  out  [DEPTH-1:0][WIDTH-1:0]  frame; data_out[r] = r-th accepted row
- row_parity  out  DEPTH  bit r = XOR of row r (pre-injection)
- col_parity  out  WIDTH  bit c = XOR over rows of bit c (pre-injection)
- frame_valid  out  1  output frame held
- frame_start  out  1  one-cycle strobe per new frame (drives decoder ready)
- frame_ack  in  1  downstream releases output frame
- frame_cnt  out  CNT_W  frames transferred, wraps

## Operation
- Accumulator: row buffer, row counter acc_cnt (0..DEPTH-1), running col parity (XOR of rows), row parity bits computed per row on acceptance, flag acc_full.
- Accept: in_valid && in_ready at an edge stores row_in at acc_cnt, acc_cnt++. Accepting row DEPTH-1 sets acc_full and wraps acc_cnt to 0.
- in_ready = !acc_full (registered state only; no combinational path from frame_ack or in_valid).
- Transfer condition: acc_full && (!frame_valid || frame_ack). On that edge: output registers load buffer and parity; if inj_en, data_out[inj_row][inj_col] inverted (parity not altered). Then acc_full cleared, col parity accumulator cleared, frame_valid=1, frame_start=1 for the next cycle only, frame_cnt++ (wraps).
- frame_ack with frame_valid && no transfer: frame_valid=0 next cycle; data_out/parity keep last values.
- frame_ack while frame_valid=0: ignored.
- Simultaneous ack and transfer: new frame loaded, frame_valid stays 1, frame_start pulses again.
- Row acceptance and transfer may coincide only when acc_full was cleared the same edge. Rows are never accepted while acc_full=1.
- Reset (any time, including mid-fill or mid-hold): partial frame discarded. All outputs and internal state to 0, except in_ready=1 once rst_n deasserts.

## Timing
- Reset values: in_ready=1 (combinational of acc_full=0), data_out=0, row_parity=0, col_parity=0, frame_valid=0, frame_start=0, frame_cnt=0.
- Last row accepted at edge N → acc_full=1, in_ready=0 after N. Transfer at N+1 if slot free, so frame_valid=1 and frame_start=1 during cycle after N+1. in_ready=1 again after N+1.
- Throughput: DEPTH+1 cycles per frame when never backpressured.
- Backpressure: frame_valid held with no ack → accumulator fills, in_ready=0 until transfer.
- inj_en/inj_row/inj_col sampled only at transfer edge.

## Structure
- Package fec_pkg: default WIDTH/DEPTH, typedef for frame (data, row_parity, col_parity), shared with decoder.
- Sub-module fec_parity_acc: accumulator buffer, counter and running parity. The top holds the output registers, handshake, injection and frame counter.

## Test plan
- Rows 1111×4, no backpressure → data_out all 1111, row_parity 0000, col_parity 0000, frame_start one cycle, frame_cnt=1, frame_valid 5 cycles after first row.
- Rows 0001,0011,0111,1111 (r0..r3) → row_parity 0101, col_parity 1010.
- Rows 1111×4, inj_en=1 row 2 col 1 → data_out[2]=1101, others 1111, parity 0000/0000. Decoder detects and corrects the error.
- Hold frame_ack=0, stream 8 rows continuously → second frame fills, in_ready=0 after 8th row. Ack pulse → frame_valid stays 1, frame_start re-pulses, frame_cnt=2, in_ready=1 next cycle.
- Accept 2 rows, assert rst_n=0 mid-cycle → outputs to 0 immediately. Then 4 rows 1010 → frame is exactly 1010×4, row_parity 0000, col_parity 0000.
- Run 256 frames → frame_cnt wraps to 0. frame_ack with frame_valid=0 → no state change.
